// File: rtl/sma_filter.sv
// Simple moving average over the last 2^LOG2_WINDOW tick-qualified samples.
// Output is floor(sum / N) with a one-cycle valid pulse per accepted sample.
module sma_filter #(
    parameter int WIDTH       = 8,
    parameter int LOG2_WINDOW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] avg_out,
    output logic             avg_valid,
    output logic             filled
);

    localparam int unsigned N  = 1 << LOG2_WINDOW;
    localparam int          SW = WIDTH + LOG2_WINDOW;

    localparam logic [LOG2_WINDOW:0]   N_CNT   = (LOG2_WINDOW + 1)'(N);
    localparam logic [LOG2_WINDOW:0]   CNT_ONE = (LOG2_WINDOW + 1)'(1);
    localparam logic [LOG2_WINDOW-1:0] PTR_ONE = LOG2_WINDOW'(1);

    logic [WIDTH-1:0]       mem [N];
    logic [LOG2_WINDOW-1:0] wr_ptr;
    logic [SW-1:0]          sum;
    logic [LOG2_WINDOW:0]   count;

    logic [WIDTH-1:0]       oldest;
    logic [SW-1:0]          next_sum;
    logic [LOG2_WINDOW:0]   count_inc;

    // Zero-initialised buffer makes warm-up samples count as zero.
    always_comb begin
        oldest    = mem[wr_ptr];
        next_sum  = sum + SW'(din) - SW'(oldest);
        count_inc = count + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= '0;
            sum       <= '0;
            count     <= '0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
            filled    <= 1'b0;
        end else if (tick) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PTR_ONE;
            sum         <= next_sum;
            avg_out     <= next_sum[SW-1:LOG2_WINDOW];
            avg_valid   <= 1'b1;
            if (count != N_CNT) begin
                count <= count_inc;
            end
            filled <= (count_inc >= N_CNT);
        end else begin
            avg_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sma_filter.sv
// Scoreboard bench for sma_filter: an N=4 instance and a default N=8 instance
// share clock and reset; expected averages are pushed at stimulus time.
module tb_sma_filter;

    typedef struct {
        int avg;
        bit fil;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick4, tick8;
    logic [7:0] din4, din8;
    logic [7:0] avg4, avg8;
    logic       valid4, valid8;
    logic       filled4, filled8;

    int vectors     = 0;
    int miscompares = 0;

    exp_t q4[$];
    exp_t q8[$];

    always #10 clk = ~clk;

    sma_filter #(.WIDTH(8), .LOG2_WINDOW(2)) u_n4 (
        .clk(clk), .rst_n(rst_n), .tick(tick4), .din(din4),
        .avg_out(avg4), .avg_valid(valid4), .filled(filled4)
    );

    sma_filter #(.WIDTH(8), .LOG2_WINDOW(3)) u_n8 (
        .clk(clk), .rst_n(rst_n), .tick(tick8), .din(din8),
        .avg_out(avg8), .avg_valid(valid8), .filled(filled8)
    );

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitors: pop one expectation per valid pulse.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid4 === 1'b1) begin
            if (q4.size() == 0) begin
                check("n4 unexpected valid", 1, 0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("n4 avg_out", int'(avg4), e.avg);
                check("n4 filled", int'(filled4), int'(e.fil));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid8 === 1'b1) begin
            if (q8.size() == 0) begin
                check("n8 unexpected valid", 1, 0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("n8 avg_out", int'(avg8), e.avg);
                check("n8 filled", int'(filled8), int'(e.fil));
            end
        end
    end

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic [7:0] v, input int ea, input bit ef);
        exp_t e;
        e.avg = ea;
        e.fil = ef;
        q4.push_back(e);
        tick4 = 1'b1;
        din4  = v;
        @(posedge clk);
        #1;
        tick4 = 1'b0;
        din4  = 8'h00;
    endtask

    task automatic drive8(input logic [7:0] v, input int ea, input bit ef);
        exp_t e;
        e.avg = ea;
        e.fil = ef;
        q8.push_back(e);
        tick8 = 1'b1;
        din8  = v;
        @(posedge clk);
        #1;
        tick8 = 1'b0;
        din8  = 8'h00;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " n4 avg_out"}, int'(avg4), 0);
        check({tag, " n4 avg_valid"}, int'(valid4), 0);
        check({tag, " n4 filled"}, int'(filled4), 0);
        check({tag, " n8 avg_out"}, int'(avg8), 0);
        check({tag, " n8 avg_valid"}, int'(valid8), 0);
        check({tag, " n8 filled"}, int'(filled8), 0);
    endtask

    initial begin
        int sat_exp[8] = '{31, 63, 95, 127, 159, 191, 223, 255};
        int ramp_in[4]  = '{4, 8, 12, 16};
        int ramp_exp[4] = '{1, 3, 6, 10};
        int b2b_in[4]   = '{20, 40, 60, 80};
        int b2b_exp[4]  = '{5, 15, 30, 50};
        int wrap_exp[4] = '{75, 50, 25, 0};

        rst_n = 1'b0;
        tick4 = 1'b0;
        tick8 = 1'b0;
        din4  = 8'hFF;
        din8  = 8'hFF;

        // Reset held 3 cycles with tick toggling and din=0xFF.
        for (int i = 0; i < 3; i++) begin
            tick4 = ~tick4;
            tick8 = ~tick8;
            @(posedge clk);
            #1;
            check_zero("reset");
        end
        rst_n = 1'b1;
        tick4 = 1'b0;
        tick8 = 1'b0;
        din4  = 8'h00;
        din8  = 8'h00;
        idle();
        check_zero("post-release");

        // Saturation on N=8.
        for (int k = 0; k < 16; k++) begin
            drive8(8'd255, (k < 8) ? sat_exp[k] : 255, k >= 7);
            idle();
        end
        check("n8 sum peak", int'(u_n8.sum), 2040);

        // Warm-up ramp on N=4.
        for (int k = 0; k < 4; k++) begin
            drive4(8'(ramp_in[k]), ramp_exp[k], k == 3);
            idle();
        end

        // Reset concurrent with a tick: sample discarded.
        rst_n = 1'b0;
        tick4 = 1'b1;
        din4  = 8'd200;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick4 = 1'b0;
        din4  = 8'h00;
        check("midreset n4 filled", int'(filled4), 0);
        check("midreset n4 avg_out", int'(avg4), 0);
        check("midreset n4 avg_valid", int'(valid4), 0);
        drive4(8'd8, 2, 1'b0);
        idle();

        // Window wrap-around on N=4.
        reset_pulse();
        for (int k = 0; k < 4; k++) begin
            drive4(8'd100, 25 * (k + 1), k == 3);
            idle();
        end
        for (int k = 0; k < 4; k++) begin
            drive4(8'd0, wrap_exp[k], 1'b1);
            idle();
        end

        // Back-to-back strobes on N=4.
        reset_pulse();
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.avg = b2b_exp[k];
            e.fil = (k == 3);
            q4.push_back(e);
            tick4 = 1'b1;
            din4  = 8'(b2b_in[k]);
            @(posedge clk);
            #1;
            check("b2b n4 avg_valid high", int'(valid4), 1);
        end
        tick4 = 1'b0;
        din4  = 8'h00;
        idle();
        check("b2b n4 avg_valid low after", int'(valid4), 0);

        repeat (3) idle();
        check("n4 scoreboard drained", q4.size(), 0);
        check("n8 scoreboard drained", q8.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sma_filter.md
# sma_filter

Simple-moving-average stage that sits directly downstream of the 1-second clock divider. Each divider tick is a sample strobe: the block captures one input sample, updates a running sum over the last 2^LOG2_WINDOW samples, and emits the truncated average with a one-cycle valid pulse. This block is the SMA half of the EMA-vs-SMA comparison path.

## Interface

- WIDTH, default 8: sample and average width in bits, unsigned.
- LOG2_WINDOW, default 3: log2 of the window depth; window N = 2^LOG2_WINDOW (8 by default). Legal range is 1..6.

- clk  input  1  system clock (50 MHz).
- rst_n  input  1  reset. One clock; reset is synchronous and active-low.
- tick  input  1  sample strobe from the clock divider. Every cycle it is high is one sample.
- din  input  WIDTH  sample value, qualified by tick.
- avg_out  output  WIDTH  current window average, floor(sum / N).
- avg_valid  output  1  one-cycle pulse; avg_out was updated on the preceding edge.
- filled  output  1  high once N samples have been accepted since reset; sticky until reset.

## Operation

- Storage: a circular buffer of N entries, each WIDTH bits; a write pointer of LOG2_WINDOW bits; a running sum of WIDTH+LOG2_WINDOW bits; a saturating fill counter of LOG2_WINDOW+1 bits.
- On a rising edge with rst_n=0, the block clears the buffer, all its entries, the pointer, the sum, the fill counter and all outputs.
- On a rising edge with rst_n=1 and tick=1:
  - oldest = buf[wr_ptr]. Because the buffer is zero-initialised, this entry is 0 until the window is full.
  - next_sum = sum + din − oldest. This is exact: no overflow and no underflow at the declared width.
  - buf[wr_ptr] <= din.
  - wr_ptr <= wr_ptr + 1, wrapping modulo N from N−1 to 0.
  - sum <= next_sum.
  - avg_out <= next_sum >> LOG2_WINDOW. This truncates and does no rounding.
  - avg_valid <= 1.
  - The fill counter increments and saturates at N. filled <= (count+1 ≥ N).
- On a rising edge with rst_n=1 and tick=0:
  - avg_valid <= 0.
  - All other state holds.
- Warm-up: before filled, avg_out divides by N even though fewer than N samples are present. The missing samples count as zero. This is intentional; it matches the EMA stage's zero start.
- Reset has priority over tick. If both are active on the same edge, the sample is discarded.
- din is ignored when tick=0.

## Timing

- Reset values:
  - avg_out = 0
  - avg_valid = 0
  - filled = 0
  - sum = 0, pointer = 0, buffer all 0
- Latency is 1 cycle. When tick is sampled high at edge k, avg_out, avg_valid and filled reflect that sample after edge k, and avg_valid stays high for exactly one cycle.
- Back-to-back ticks on consecutive cycles are fully supported, with one sample per cycle. In that case avg_valid stays high continuously.
- A single avg_valid pulse is produced per tick cycle, with no pipeline bubbles.
- filled rises on the edge that accepts the N-th sample. After that it never falls without reset.
- A reset mid-window:
  - takes effect on the next edge;
  - the next tick after reset release is treated as sample 1 of a fresh window.
- All outputs are registered, with no combinational path from din or tick to any output.

## Test plan

- Reset: hold rst_n=0 for 3 cycles with tick toggling and din=0xFF, then release. Required: avg_out=0, avg_valid=0, filled=0 throughout reset and on the first cycle after release.
- Warm-up ramp, with LOG2_WINDOW=2: single-cycle ticks with din=4, 8, 12, 16. Required:
  - avg_out=1, 3, 6, 10, each with a single avg_valid pulse one cycle after its tick;
  - filled rises with the 4th sample.
- Saturation, with the default WIDTH=8 and N=8: 16 ticks of din=255. Required:
  - avg_out climbs 31, 63, 95, 127, 159, 191, 223, 255, then holds 255;
  - sum peaks at 2040 with no wrap.
- Window wrap-around, with N=4: 4 ticks of din=100, then ticks of din=0, 0, 0, 0. Required: avg_out=75, 50, 25, 0, and filled remains 1.
- Back-to-back strobes, with N=4: tick held high for 4 consecutive cycles with din=20, 40, 60, 80. Required:
  - avg_valid high for 4 consecutive cycles;
  - avg_out=5, 15, 30, 50.
- Reset mid-operation, with N=4: after the ramp test, pulse rst_n low for 1 cycle concurrent with tick and din=200, then tick with din=8. Required:
  - the din=200 sample is discarded;
  - filled=0;
  - avg_out=2 after the next tick.
